// File: rtl/gpr_mp_if.sv
// gpr_mp_if: bus bundle for the multi-port register file.
// Ports (bit slice i of each bus belongs to read/write port i):
//   clr      request a full clear sweep
//   busy     clear sweep in progress
//   wr_rdy   writes accepted this cycle
//   rd_adr   NR*AW read addresses
//   rd_dat   NR*WIDTH read data (combinational)
//   wr_en    NW write enables
//   wr_adr   NW*AW write addresses
//   wr_dat   NW*WIDTH write data
//   wr_coll  registered same-address write collision flag
// Modports: master drives requests (issue/writeback side), slave is the register file.
interface gpr_mp_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NR    = 3,
    parameter int unsigned NW    = 1
);
    logic                clr;
    logic                busy;
    logic                wr_rdy;
    logic                wr_coll;
    logic [NR*AW-1:0]    rd_adr;
    logic [NR*WIDTH-1:0] rd_dat;
    logic [NW-1:0]       wr_en;
    logic [NW*AW-1:0]    wr_adr;
    logic [NW*WIDTH-1:0] wr_dat;

    modport master (
        output clr, rd_adr, wr_en, wr_adr, wr_dat,
        input  busy, wr_rdy, rd_dat, wr_coll
    );

    modport slave (
        input  clr, rd_adr, wr_en, wr_adr, wr_dat,
        output busy, wr_rdy, rd_dat, wr_coll
    );
endinterface

// File: rtl/gpr_mp.sv
// gpr_mp: parametrised multi-port general-purpose register file with a
// hardware clear sweep, highest-port-wins write priority, a registered
// write-collision flag and optional same-cycle write-to-read bypass.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-high reset (restarts the clear sweep)
//   bus   gpr_mp_if.slave: clr, busy, wr_rdy, rd_adr, rd_dat, wr_en,
//         wr_adr, wr_dat, wr_coll
// Build option: define GPR_BYPASS_EN to forward same-cycle write data to
// matching read ports (highest-numbered matching write port wins).
module gpr_mp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NR    = 3,
    parameter int unsigned NW    = 1
) (
    input  logic     clk,
    input  logic     rst,
    gpr_mp_if.slave  bus
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             wr_coll_q, wr_coll_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             busy_c;
    logic [NR*WIDTH-1:0] rd_dat_c;
    logic [AW-1:0]    radr [NR];
    logic [AW-1:0]    wadr [NW];
    logic [WIDTH-1:0] wdat [NW];

    // Address is backed by a real entry (DEPTH may be below 2^AW).
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    // Unpack the flat port buses.
    for (genvar g = 0; g < NR; g++) begin : g_rd
        assign radr[g] = bus.rd_adr[g*AW +: AW];
    end
    for (genvar g = 0; g < NW; g++) begin : g_wr
        assign wadr[g] = bus.wr_adr[g*AW +: AW];
        assign wdat[g] = bus.wr_dat[g*WIDTH +: WIDTH];
    end

    assign busy_c = (state_q == ST_CLEAR);

    // Next state, sweep counter, collision flag and array update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_coll_d = 1'b0;
        mem_d     = mem_q;
        if (state_q == ST_CLEAR) begin
            // The sweep owns the write path; external writes and clr are ignored.
            mem_d[cnt_q] = '0;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end else begin
            for (int unsigned i = 0; i < NW; i++) begin
                for (int unsigned j = i + 1; j < NW; j++) begin
                    if (bus.wr_en[i] && bus.wr_en[j] && in_range(wadr[i]) &&
                        (wadr[i] == wadr[j])) begin
                        wr_coll_d = 1'b1;
                    end
                end
            end
            // Ascending order so the highest-numbered port lands last.
            for (int unsigned w = 0; w < NW; w++) begin
                if (bus.wr_en[w] && in_range(wadr[w])) begin
                    mem_d[wadr[w]] = wdat[w];
                end
            end
            // Writes above still happen this edge; the sweep overwrites them.
            if (bus.clr) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        end
    end

    // Control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            wr_coll_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_coll_q <= wr_coll_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read ports: unswept or missing entries always read as zero.
    always_comb begin
        rd_dat_c = '0;
        for (int unsigned r = 0; r < NR; r++) begin
            if (!busy_c && in_range(radr[r])) begin
                rd_dat_c[r*WIDTH +: WIDTH] = mem_q[radr[r]];
            end
`ifdef GPR_BYPASS_EN
            if (!busy_c) begin
                for (int unsigned w = 0; w < NW; w++) begin
                    if (bus.wr_en[w] && in_range(wadr[w]) && (wadr[w] == radr[r])) begin
                        rd_dat_c[r*WIDTH +: WIDTH] = wdat[w];
                    end
                end
            end
`else
`endif
        end
    end

    assign bus.busy    = busy_c;
    assign bus.wr_rdy  = ~busy_c;
    assign bus.wr_coll = wr_coll_q;
    assign bus.rd_dat  = rd_dat_c;
endmodule
